ada_hazard_sb: RTL and testbench

Parametrised hazard-detection, forwarding and stall-control unit for the ADA pipeline. It generalises the fixed two-port, EX/MEM/WB hazard logic to N read ports and M forwarding stages, and makes the load-data availability stage configurable. It adds a register scoreboard that tracks outstanding long-latency (multiply/divide) writebacks. The unit sits beside the ID stage and drives every pipeline-register stall and the operand-forwarding muxes.

---
 rtl/ada_hazard_sb_if.sv | 57 +++++
 rtl/ada_hazard_sb.sv | 118 +++++++++++
 tb/tb_ada_hazard_sb.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ada_hazard_sb_if.sv
// Signal bundle between the ID-stage hazard unit and the pipeline.
// lu_issue and lu_done are single-cycle valid strobes with no ready. The unit always takes them in and records an illegal one in sb_error.
interface ada_hazard_sb_if #(
  parameter int NUM_PORTS  = 2,
  parameter int FWD_STAGES = 3
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  logic [NUM_PORTS*5-1:0]    id_gpr_port;
  logic [NUM_PORTS-1:0]      id_port_re;
  logic [4:0]                id_gpr_wa;
  logic                      id_gpr_we;
  logic                      id_lu_op;
  logic [FWD_STAGES*5-1:0]   stage_gpr_wa;
  logic [FWD_STAGES-1:0]     stage_gpr_we;
  logic [FWD_STAGES-1:0]     stage_data_read;
  logic                      lu_issue;
  logic [4:0]                lu_issue_wa;
  logic                      lu_done;
  logic [4:0]                lu_done_wa;
  logic                      lu_flush;
  logic                      if_mem_request_stall;
  logic                      mem_request_stall;
  logic                      if_exception_stall;
  logic                      id_exception_stall;
  logic                      ex_exception_stall;
  logic                      mem_exception_stall;
  logic                      ex_exu_stall;
  logic [NUM_PORTS*SELW-1:0] forward_select;
  logic                      if_stall;
  logic                      id_stall;
  logic                      ex_stall;
  logic                      mem_stall;
  logic                      wb_stall;
  logic [31:0]               sb_busy;
  logic                      sb_error;

  modport master (
    output id_gpr_port, id_port_re, id_gpr_wa, id_gpr_we, id_lu_op,
           stage_gpr_wa, stage_gpr_we, stage_data_read,
           lu_issue, lu_issue_wa, lu_done, lu_done_wa, lu_flush,
           if_mem_request_stall, mem_request_stall, if_exception_stall,
           id_exception_stall, ex_exception_stall, mem_exception_stall, ex_exu_stall,
    input  forward_select, if_stall, id_stall, ex_stall, mem_stall, wb_stall,
           sb_busy, sb_error
  );

  modport slave (
    input  id_gpr_port, id_port_re, id_gpr_wa, id_gpr_we, id_lu_op,
           stage_gpr_wa, stage_gpr_we, stage_data_read,
           lu_issue, lu_issue_wa, lu_done, lu_done_wa, lu_flush,
           if_mem_request_stall, mem_request_stall, if_exception_stall,
           id_exception_stall, ex_exception_stall, mem_exception_stall, ex_exu_stall,
    output forward_select, if_stall, id_stall, ex_stall, mem_stall, wb_stall,
           sb_busy, sb_error
  );
endinterface

// File: rtl/ada_hazard_sb.sv
// Hazard detection, operand forwarding and stall control for the ADA ID stage,
// with a scoreboard for in-flight long-latency (mul/div) writebacks.
module ada_hazard_sb #(
  parameter int NUM_PORTS       = 2,
  parameter int FWD_STAGES      = 3,
  parameter int LOAD_FWD_STAGE  = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk,
  input logic             rst_n,
  ada_hazard_sb_if.slave  bus
);
  localparam int SELW = $clog2(FWD_STAGES + 1);
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  logic [FWD_STAGES-1:0]     match [NUM_PORTS];
  logic [FWD_STAGES-1:0]     blocked;
  logic [NUM_PORTS-1:0]      port_load_stall;
  logic [NUM_PORTS*SELW-1:0] fsel;
  logic                      load_stall;

  always_comb begin
    for (int k = 0; k < FWD_STAGES; k++) begin
      blocked[k] = bus.stage_data_read[k] && (k < LOAD_FWD_STAGE);
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        match[p][k] = bus.id_port_re[p] && (bus.id_gpr_port[5*p +: 5] != 5'd0) &&
                      (bus.id_gpr_port[5*p +: 5] == bus.stage_gpr_wa[5*k +: 5]) &&
                      bus.stage_gpr_we[k];
      end
    end
  end

  // Scan oldest to youngest so the lowest (youngest) stage overwrites last.
  always_comb begin
    fsel            = '0;
    port_load_stall = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (match[p][k]) begin
          port_load_stall[p] = blocked[k];
          if (!blocked[k]) fsel[p*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
    load_stall = |port_load_stall;
  end

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
  logic          full, issue_ok, issue_err, done_ok, done_err;

  assign full      = (cnt_q == CW'(MAX_OUTSTANDING));
  assign issue_ok  = bus.lu_issue && !full;
  assign issue_err = bus.lu_issue && full;
  assign done_ok   = bus.lu_done && busy_q[bus.lu_done_wa];
  assign done_err  = bus.lu_done && !busy_q[bus.lu_done_wa];

  // Clear before set so an issue and a done to the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (done_ok) busy_d[bus.lu_done_wa] = 1'b0;
    if (issue_ok && (bus.lu_issue_wa != 5'd0)) busy_d[bus.lu_issue_wa] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = cnt_q;
    if (issue_ok && !done_ok)                         cnt_d = cnt_q + CW'(1);
    else if (!issue_ok && done_ok && (cnt_q != '0))   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (bus.lu_flush) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (issue_err || done_err) err_q <= 1'b1;
    end
  end

  logic       rd_hit, waw_hit, lu_full, sb_stall;
  logic [4:0] addr;

  always_comb begin
    rd_hit = 1'b0;
    addr   = 5'd0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr = bus.id_gpr_port[5*p +: 5];
      if (bus.id_port_re[p] && (addr != 5'd0) &&
          (busy_q[addr] || (bus.lu_issue && (addr == bus.lu_issue_wa))))
        rd_hit = 1'b1;
    end
    waw_hit  = bus.id_gpr_we && busy_q[bus.id_gpr_wa];
    lu_full  = bus.id_lu_op && full;
    // Scoreboard is meaningless while reset is held, including the issue bypass.
    sb_stall = rst_n && (rd_hit || waw_hit || lu_full);
  end

  logic mem_s, ex_s, id_s;
  assign mem_s = bus.mem_exception_stall | bus.mem_request_stall;
  assign ex_s  = bus.ex_exception_stall | bus.ex_exu_stall | mem_s;
  assign id_s  = bus.id_exception_stall | load_stall | sb_stall | ex_s;

  assign bus.mem_stall      = mem_s;
  assign bus.wb_stall       = mem_s;
  assign bus.ex_stall       = ex_s;
  assign bus.id_stall       = id_s;
  assign bus.if_stall       = bus.if_exception_stall | bus.if_mem_request_stall | id_s;
  assign bus.forward_select = fsel;
  assign bus.sb_busy        = busy_q;
  assign bus.sb_error       = err_q;
endmodule

// File: tb/tb_ada_hazard_sb.sv
// Directed bench for ada_hazard_sb: forwarding, load-use, stall chain,
// scoreboard set/clear/overflow/flush and asynchronous reset.
module tb_ada_hazard_sb;
  logic clk;
  logic rst_n;

  ada_hazard_sb_if #(.NUM_PORTS(2), .FWD_STAGES(3)) bus ();

  ada_hazard_sb #(
    .NUM_PORTS(2), .FWD_STAGES(3), .LOAD_FWD_STAGE(1), .MAX_OUTSTANDING(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  wire [4:0] stv = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall, bus.wb_stall};

  // driver tasks
  task automatic clear_in();
    bus.id_gpr_port = '0;  bus.id_port_re = '0;
    bus.id_gpr_wa = '0;    bus.id_gpr_we = 1'b0;   bus.id_lu_op = 1'b0;
    bus.stage_gpr_wa = '0; bus.stage_gpr_we = '0;  bus.stage_data_read = '0;
    bus.lu_issue = 1'b0;   bus.lu_issue_wa = '0;
    bus.lu_done = 1'b0;    bus.lu_done_wa = '0;    bus.lu_flush = 1'b0;
    bus.if_mem_request_stall = 1'b0; bus.mem_request_stall = 1'b0;
    bus.if_exception_stall = 1'b0;   bus.id_exception_stall = 1'b0;
    bus.ex_exception_stall = 1'b0;   bus.mem_exception_stall = 1'b0;
    bus.ex_exu_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0h, expected value missing from queue", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    #3;
    // reset values and combinational paths while reset is held
    push(32'h0); push(32'h0);
    settle();
    check("rst_busy", bus.sb_busy);
    check("rst_err", {31'b0, bus.sb_error});

    bus.mem_request_stall = 1'b1;
    push(32'h1F);
    settle();
    check("rst_chain_mem", {27'b0, stv});

    bus.mem_request_stall = 1'b0;
    bus.id_gpr_port = 10'd4; bus.id_port_re = 2'b01;
    bus.lu_issue = 1'b1; bus.lu_issue_wa = 5'd4;
    push(32'h0);
    settle();
    check("rst_no_sb_stall", {27'b0, stv});
    clear_in();
    #1 rst_n = 1'b1;

    // forward from youngest matching stage
    tick(); clear_in();
    bus.id_gpr_port = {5'd0, 5'd5}; bus.id_port_re = 2'b01;
    bus.stage_gpr_wa = {5'd5, 5'd0, 5'd5}; bus.stage_gpr_we = 3'b101;
    push(32'h1); push(32'h0);
    settle();
    check("fwd_ex", {28'b0, bus.forward_select});
    check("fwd_ex_stall", {27'b0, stv});

    bus.stage_gpr_we = 3'b100;
    push(32'h3);
    settle();
    check("fwd_wb", {28'b0, bus.forward_select});

    // load-use at EX stalls, at MEM forwards
    tick(); clear_in();
    bus.id_gpr_port = {5'd7, 5'd0}; bus.id_port_re = 2'b10;
    bus.stage_gpr_wa = {5'd0, 5'd0, 5'd7}; bus.stage_gpr_we = 3'b001; bus.stage_data_read = 3'b001;
    push(32'h18); push(32'h0);
    settle();
    check("load_ex_stall", {27'b0, stv});
    check("load_ex_fsel", {28'b0, bus.forward_select});

    bus.stage_gpr_wa = {5'd0, 5'd7, 5'd0}; bus.stage_gpr_we = 3'b010; bus.stage_data_read = 3'b010;
    push(32'h8); push(32'h0);
    settle();
    check("load_mem_fsel", {28'b0, bus.forward_select});
    check("load_mem_stall", {27'b0, stv});

    // r0 and disabled ports never forward or stall
    tick(); clear_in();
    bus.id_gpr_port = {5'd5, 5'd0}; bus.id_port_re = 2'b01;
    bus.stage_gpr_wa = {5'd0, 5'd5, 5'd0}; bus.stage_gpr_we = 3'b011; bus.stage_data_read = 3'b001;
    push(32'h0); push(32'h0);
    settle();
    check("r0_dis_fsel", {28'b0, bus.forward_select});
    check("r0_dis_stall", {27'b0, stv});

    // stall chain
    tick(); clear_in();
    bus.ex_exu_stall = 1'b1;
    push(32'h1C); settle(); check("chain_exu", {27'b0, stv});
    bus.ex_exu_stall = 1'b0; bus.if_mem_request_stall = 1'b1;
    push(32'h10); settle(); check("chain_ifmem", {27'b0, stv});
    bus.if_mem_request_stall = 1'b0; bus.id_exception_stall = 1'b1;
    push(32'h18); settle(); check("chain_idexc", {27'b0, stv});
    bus.id_exception_stall = 1'b0; bus.mem_exception_stall = 1'b1;
    push(32'h1F); settle(); check("chain_memexc", {27'b0, stv});

    // scoreboard: issue r9, dependent read stalls until the cycle after done
    tick(); clear_in();
    bus.id_gpr_port = {5'd0, 5'd9}; bus.id_port_re = 2'b01;
    bus.lu_issue = 1'b1; bus.lu_issue_wa = 5'd9;
    push(32'h18); push(32'h0);
    settle();
    check("sb_bypass_stall", {27'b0, stv});
    check("sb_bypass_busy", bus.sb_busy);
    for (int i = 1; i <= 3; i++) begin
      tick();
      bus.lu_issue = 1'b0;
      if (i == 2) begin
        bus.id_port_re = 2'b00; bus.id_gpr_we = 1'b1; bus.id_gpr_wa = 5'd9;
      end else begin
        bus.id_port_re = 2'b01; bus.id_gpr_we = 1'b0; bus.id_gpr_wa = 5'd0;
      end
      push(32'h18); push(32'h200);
      settle();
      check((i == 2) ? "sb_waw_stall" : "sb_raw_stall", {27'b0, stv});
      check("sb_busy9", bus.sb_busy);
    end
    tick();
    bus.lu_done = 1'b1; bus.lu_done_wa = 5'd9;
    push(32'h18);
    settle();
    check("sb_done_cycle_stall", {27'b0, stv});
    tick();
    bus.lu_done = 1'b0;
    push(32'h0); push(32'h0); push(32'h0);
    settle();
    check("sb_after_done_stall", {27'b0, stv});
    check("sb_after_done_busy", bus.sb_busy);
    check("sb_after_done_err", {31'b0, bus.sb_error});

    // four outstanding ops fill the unit
    clear_in();
    for (int r = 1; r <= 4; r++) begin
      tick();
      bus.lu_issue = 1'b1; bus.lu_issue_wa = 5'(r);
    end
    tick();
    bus.lu_issue = 1'b0; bus.id_lu_op = 1'b1;
    push(32'h18); push(32'h1E);
    settle();
    check("full_lu_stall", {27'b0, stv});
    check("full_busy", bus.sb_busy);
    tick();
    bus.lu_issue = 1'b1; bus.lu_issue_wa = 5'd5;
    push(32'h0);
    settle();
    check("overflow_err_pre", {31'b0, bus.sb_error});
    tick();
    bus.lu_issue = 1'b0;
    push(32'h1); push(32'h1E); push(32'h18);
    settle();
    check("overflow_err", {31'b0, bus.sb_error});
    check("overflow_busy", bus.sb_busy);
    check("overflow_still_full", {27'b0, stv});
    tick();
    bus.lu_done = 1'b1; bus.lu_done_wa = 5'd1;
    push(32'h18);
    settle();
    check("full_done_cycle", {27'b0, stv});
    tick();
    bus.lu_done = 1'b0;
    push(32'h0); push(32'h1C);
    settle();
    check("not_full_after_done", {27'b0, stv});
    check("busy_after_done", bus.sb_busy);

    // asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    push(32'h0); push(32'h0);
    check("async_rst_busy", bus.sb_busy);
    check("async_rst_err", {31'b0, bus.sb_error});
    #2 rst_n = 1'b1;

    // same-cycle issue and done, then flush, then a stray done
    tick(); clear_in();
    bus.lu_issue = 1'b1; bus.lu_issue_wa = 5'd3;
    tick();
    bus.lu_done = 1'b1; bus.lu_done_wa = 5'd3;
    push(32'h8);
    settle();
    check("issue_done_pre", bus.sb_busy);
    tick();
    bus.lu_done = 1'b0; bus.lu_issue_wa = 5'd10;
    push(32'h8); push(32'h0);
    settle();
    check("issue_done_busy", bus.sb_busy);
    check("issue_done_err", {31'b0, bus.sb_error});
    tick(); bus.lu_issue_wa = 5'd11;
    tick(); bus.lu_issue_wa = 5'd12;
    tick();
    bus.lu_issue = 1'b0; bus.id_lu_op = 1'b1;
    push(32'h18); push(32'h1C08);
    settle();
    check("count_unchanged_full", {27'b0, stv});
    check("four_busy", bus.sb_busy);
    tick();
    bus.id_lu_op = 1'b0; bus.lu_flush = 1'b1; bus.lu_issue = 1'b1; bus.lu_issue_wa = 5'd6;
    tick();
    bus.lu_flush = 1'b0; bus.lu_issue = 1'b0; bus.id_lu_op = 1'b1;
    push(32'h0); push(32'h0); push(32'h0);
    settle();
    check("flush_busy", bus.sb_busy);
    check("flush_count", {27'b0, stv});
    check("flush_err", {31'b0, bus.sb_error});
    tick();
    bus.id_lu_op = 1'b0; bus.lu_done = 1'b1; bus.lu_done_wa = 5'd3;
    tick();
    bus.lu_done = 1'b0;
    push(32'h1); push(32'h0);
    settle();
    check("stray_done_err", {31'b0, bus.sb_error});
    check("stray_done_busy", bus.sb_busy);

    // final report
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL queue_drain: observed %0d leftover expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
